// File: rtl/exec_muldiv_arbiter_if.sv
// exec_muldiv_arbiter_if
// Bundles the lane request side, the shared unit handshake and the per-lane
// result/stall outputs of the mul/div arbiter.
//   lane inputs  : controlInReqN, controlInOpN, dataInRmN, dataInRnN (N = 1, 2)
//   unit side    : controlOutUnitStart/Op, dataOutUnitA/B, controlInUnitDone,
//                  dataInUnitResult
//   lane outputs : dataOutResN, controlOutResValidN, controlOutStall,
//                  controlOutTimeout
// slave modport is the arbiter; master modport is whoever drives the lanes
// and emulates the unit.
interface exec_muldiv_arbiter_if #(
    parameter int DATA_W = 40,
    parameter int OP_W   = 5
);
    logic              controlInReq1;
    logic [OP_W-1:0]   controlInOp1;
    logic [DATA_W-1:0] dataInRm1;
    logic [DATA_W-1:0] dataInRn1;
    logic              controlInReq2;
    logic [OP_W-1:0]   controlInOp2;
    logic [DATA_W-1:0] dataInRm2;
    logic [DATA_W-1:0] dataInRn2;

    logic              controlOutUnitStart;
    logic [OP_W-1:0]   controlOutUnitOp;
    logic [DATA_W-1:0] dataOutUnitA;
    logic [DATA_W-1:0] dataOutUnitB;
    logic              controlInUnitDone;
    logic [DATA_W-1:0] dataInUnitResult;

    logic [DATA_W-1:0] dataOutRes1;
    logic [DATA_W-1:0] dataOutRes2;
    logic              controlOutResValid1;
    logic              controlOutResValid2;
    logic              controlOutStall;
    logic              controlOutTimeout;

    modport slave (
        input  controlInReq1, controlInOp1, dataInRm1, dataInRn1,
        input  controlInReq2, controlInOp2, dataInRm2, dataInRn2,
        input  controlInUnitDone, dataInUnitResult,
        output controlOutUnitStart, controlOutUnitOp, dataOutUnitA, dataOutUnitB,
        output dataOutRes1, dataOutRes2, controlOutResValid1, controlOutResValid2,
        output controlOutStall, controlOutTimeout
    );

    modport master (
        output controlInReq1, controlInOp1, dataInRm1, dataInRn1,
        output controlInReq2, controlInOp2, dataInRm2, dataInRn2,
        output controlInUnitDone, dataInUnitResult,
        input  controlOutUnitStart, controlOutUnitOp, dataOutUnitA, dataOutUnitB,
        input  dataOutRes1, dataOutRes2, controlOutResValid1, controlOutResValid2,
        input  controlOutStall, controlOutTimeout
    );
endinterface

// File: rtl/exec_muldiv_arbiter.sv
// exec_muldiv_arbiter
// Shares one multi-cycle multiply/divide unit between execute lanes 1 and 2.
// Grants round-robin, latches the granted lane's operands, runs the
// start/done handshake under a watchdog and routes the result back to the
// lane. Stalls the execute stage while any long-latency op is outstanding.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : exec_muldiv_arbiter_if.slave (lane requests, unit handshake,
//              per-lane results, stall and timeout)
//
// state  | meaning
// IDLE   | look at unserved requests, grant one lane, latch its operands
// ISSUE  | start pulse on the unit, arm the watchdog
// WAIT   | wait for unit done or watchdog expiry, capture result
// RETURN | result valid pulse to granted lane, mark lane served
module exec_muldiv_arbiter #(
    parameter int DATA_W  = 40,
    parameter int OP_W    = 5,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    exec_muldiv_arbiter_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} stateType;

    stateType          state;
    logic              grantLane2;
    logic [1:0]        served;
    logic              prioLane2;
    logic [WD_W-1:0]   watchdog;
    logic [OP_W-1:0]   opLatch;
    logic [DATA_W-1:0] aLatch;
    logic [DATA_W-1:0] bLatch;
    logic              unitStart;
    logic [DATA_W-1:0] res1;
    logic [DATA_W-1:0] res2;
    logic              resValid1;
    logic              resValid2;
    logic              timeoutPulse;

    logic [1:0]        pending;
    logic              pickLane2;

    // A lane that was already served keeps its req high until the pipeline
    // advances; masking it here stops the same op being issued twice.
    assign pending = {bus.controlInReq2, bus.controlInReq1} & ~served;

    always_comb begin
        pickLane2 = 1'b0;
        if (pending == 2'b10) begin
            pickLane2 = 1'b1;
        end else if (pending == 2'b11) begin
            pickLane2 = prioLane2;
        end
    end

    // Combinational so the pipeline freezes in the same cycle a request shows up.
    assign bus.controlOutStall     = (state != IDLE) | (|pending);
    assign bus.controlOutUnitStart = unitStart;
    assign bus.controlOutUnitOp    = opLatch;
    assign bus.dataOutUnitA        = aLatch;
    assign bus.dataOutUnitB        = bLatch;
    assign bus.dataOutRes1         = res1;
    assign bus.dataOutRes2         = res2;
    assign bus.controlOutResValid1 = resValid1;
    assign bus.controlOutResValid2 = resValid2;
    assign bus.controlOutTimeout   = timeoutPulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grantLane2   <= 1'b0;
            served       <= 2'b00;
            prioLane2    <= 1'b0;
            watchdog     <= '0;
            opLatch      <= '0;
            aLatch       <= '0;
            bLatch       <= '0;
            unitStart    <= 1'b0;
            res1         <= '0;
            res2         <= '0;
            resValid1    <= 1'b0;
            resValid2    <= 1'b0;
            timeoutPulse <= 1'b0;
        end else begin
            unitStart    <= 1'b0;
            resValid1    <= 1'b0;
            resValid2    <= 1'b0;
            timeoutPulse <= 1'b0;

            case (state)
                IDLE: begin
                    if (|pending) begin
                        grantLane2 <= pickLane2;
                        if (&pending) begin
                            prioLane2 <= ~prioLane2;
                        end
                        opLatch   <= pickLane2 ? bus.controlInOp2 : bus.controlInOp1;
                        aLatch    <= pickLane2 ? bus.dataInRm2    : bus.dataInRm1;
                        bLatch    <= pickLane2 ? bus.dataInRn2    : bus.dataInRn1;
                        unitStart <= 1'b1;
                        state     <= ISSUE;
                    end else begin
                        served <= 2'b00;
                    end
                end

                ISSUE: begin
                    watchdog <= WD_W'(TIMEOUT);
                    state    <= WAIT;
                end

                // Result and valid are registered on leaving WAIT so that the
                // valid pulse lines up with the RETURN cycle.
                WAIT: begin
                    watchdog <= watchdog - 1'b1;
                    if (bus.controlInUnitDone) begin
                        if (grantLane2) begin
                            res2      <= bus.dataInUnitResult;
                            resValid2 <= 1'b1;
                        end else begin
                            res1      <= bus.dataInUnitResult;
                            resValid1 <= 1'b1;
                        end
                        state <= RETURN;
                    end else if (watchdog == WD_W'(1)) begin
                        if (grantLane2) begin
                            res2      <= '0;
                            resValid2 <= 1'b1;
                        end else begin
                            res1      <= '0;
                            resValid1 <= 1'b1;
                        end
                        timeoutPulse <= 1'b1;
                        state        <= RETURN;
                    end
                end

                RETURN: begin
                    served[grantLane2] <= 1'b1;
                    state              <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_muldiv_arbiter.sv
module tb_exec_muldiv_arbiter;
    localparam int DW  = 40;
    localparam int OW  = 5;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst;

    exec_muldiv_arbiter_if #(.DATA_W(DW), .OP_W(OW)) bus ();

    exec_muldiv_arbiter #(.DATA_W(DW), .OP_W(OW), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chkBit(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: actual=%b required=%b", name, cyc, got, exp);
        end
    endtask

    task automatic chkWord(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: actual=%0h required=%0h", name, cyc, got, exp);
        end
    endtask

    // Advance to posedge+1 of cycle k (where inputs for cycle k are driven).
    task automatic driveAt(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance to the negedge of cycle k (where outputs of cycle k are sampled).
    task automatic atNeg(input int k);
        driveAt(k);
        @(negedge clk);
    endtask

    // ---------------- unit emulation ----------------
    int unitLat = 0;          // 0: unit never answers
    int doneAt  = -1;
    int spurQ[$];

    function automatic logic [DW-1:0] unitCalc(input logic [OW-1:0] op,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        if (op == OW'(1)) return (b == '0) ? '0 : a / b;
        return a * b;
    endfunction

    initial begin
        bus.controlInUnitDone = 1'b0;
        bus.dataInUnitResult  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.controlInUnitDone = 1'b0;
            bus.dataInUnitResult  = '0;
            if (cyc == doneAt) begin
                bus.controlInUnitDone = 1'b1;
                bus.dataInUnitResult  = unitCalc(bus.controlOutUnitOp, bus.dataOutUnitA, bus.dataOutUnitB);
                doneAt = -1;
            end
            foreach (spurQ[i]) begin
                if (spurQ[i] == cyc) begin
                    bus.controlInUnitDone = 1'b1;
                    bus.dataInUnitResult  = 40'hDEADBEEF01;
                end
            end
            if (bus.controlOutUnitStart === 1'b1 && unitLat > 0) doneAt = cyc + unitLat;
        end
    end

    // ---------------- transaction-timeline model ----------------
    // A service granted in cycle g starts in g+1, may complete from g+2 up to
    // g+1+TMO, and returns the cycle after completion.
    bit               checkEn = 1'b0;
    int               mActive = 0;
    int               mLane   = 0;
    int               mG      = 0;
    int               mRet    = -1;
    int               mPrio   = 1;
    bit               mTmo    = 1'b0;
    logic [1:0]       mServed = 2'b00;
    logic [1:0]       mPend;
    logic [DW-1:0]    mRes1 = '0;
    logic [DW-1:0]    mRes2 = '0;
    logic [DW-1:0]    mA = '0;
    logic [DW-1:0]    mB = '0;
    logic [OW-1:0]    mOp = '0;

    always @(negedge clk) begin
        if (checkEn) begin
            mPend = {bus.controlInReq2, bus.controlInReq1} & ~mServed;
            chkBit("mdl_stall", bus.controlOutStall, (mActive != 0) || (mPend != 2'b00));
            chkBit("mdl_start", bus.controlOutUnitStart, (mActive != 0) && (cyc == mG + 1));
            chkBit("mdl_valid1", bus.controlOutResValid1, (mActive != 0) && (cyc == mRet) && (mLane == 1));
            chkBit("mdl_valid2", bus.controlOutResValid2, (mActive != 0) && (cyc == mRet) && (mLane == 2));
            chkBit("mdl_timeout", bus.controlOutTimeout, (mActive != 0) && (cyc == mRet) && mTmo);
            chkWord("mdl_res1", bus.dataOutRes1, mRes1);
            chkWord("mdl_res2", bus.dataOutRes2, mRes2);
            if (mActive != 0 && cyc >= mG + 1 && (mRet < 0 || cyc < mRet)) begin
                chkWord("mdl_unitOp", DW'(bus.controlOutUnitOp), DW'(mOp));
                chkWord("mdl_unitA", bus.dataOutUnitA, mA);
                chkWord("mdl_unitB", bus.dataOutUnitB, mB);
            end

            if (rst) begin
                mActive = 0; mServed = 2'b00; mPrio = 1; mRet = -1; mTmo = 1'b0;
                mRes1 = '0; mRes2 = '0;
            end else if (mActive == 0) begin
                if (mPend != 2'b00) begin
                    if (mPend == 2'b11) begin
                        mLane = mPrio;
                        mPrio = 3 - mPrio;
                    end else begin
                        mLane = mPend[0] ? 1 : 2;
                    end
                    mActive = 1; mG = cyc; mRet = -1; mTmo = 1'b0;
                    mOp = (mLane == 1) ? bus.controlInOp1 : bus.controlInOp2;
                    mA  = (mLane == 1) ? bus.dataInRm1    : bus.dataInRm2;
                    mB  = (mLane == 1) ? bus.dataInRn1    : bus.dataInRn2;
                end else begin
                    mServed = 2'b00;
                end
            end else if (mRet < 0) begin
                if (cyc >= mG + 2 && bus.controlInUnitDone === 1'b1) begin
                    mRet = cyc + 1;
                    if (mLane == 1) mRes1 = bus.dataInUnitResult; else mRes2 = bus.dataInUnitResult;
                end else if (cyc == mG + 1 + TMO) begin
                    mRet = cyc + 1;
                    mTmo = 1'b1;
                    if (mLane == 1) mRes1 = '0; else mRes2 = '0;
                end
            end else if (cyc == mRet) begin
                mActive = 0;
                if (mLane == 1) mServed[0] = 1'b1; else mServed[1] = 1'b1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_time_limit: actual=expired required=finished");
        $fatal(1, "time limit");
    end

    // ---------------- directed stimulus ----------------
    int t0;
    int t1;

    initial begin
        rst = 1'b1;
        bus.controlInReq1 = 1'b0; bus.controlInOp1 = '0; bus.dataInRm1 = '0; bus.dataInRn1 = '0;
        bus.controlInReq2 = 1'b0; bus.controlInOp2 = '0; bus.dataInRm2 = '0; bus.dataInRn2 = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkEn = 1'b1;
        @(negedge clk);
        chkBit("rst_stall", bus.controlOutStall, 1'b0);
        chkBit("rst_start", bus.controlOutUnitStart, 1'b0);
        chkWord("rst_res1", bus.dataOutRes1, 40'd0);
        chkWord("rst_res2", bus.dataOutRes2, 40'd0);
        chkBit("rst_timeout", bus.controlOutTimeout, 1'b0);
        chkWord("rst_unitA", bus.dataOutUnitA, 40'd0);
        driveAt(cyc + 1);
        rst = 1'b0;

        // 1: single lane 1 multiply, L=4, spurious done in IDLE/ISSUE/RETURN
        t0 = cyc + 2; unitLat = 4; spurQ = '{t0, t0 + 1, t0 + 6};
        driveAt(t0);
        bus.controlInReq1 = 1'b1; bus.controlInOp1 = 5'd0; bus.dataInRm1 = 40'd6; bus.dataInRn1 = 40'd7;
        atNeg(t0);     chkBit("t1_stall_c0", bus.controlOutStall, 1'b1);
        atNeg(t0 + 1); chkBit("t1_start", bus.controlOutUnitStart, 1'b1);
                       chkWord("t1_unitA", bus.dataOutUnitA, 40'd6);
                       chkWord("t1_unitB", bus.dataOutUnitB, 40'd7);
        atNeg(t0 + 6); chkBit("t1_valid1", bus.controlOutResValid1, 1'b1);
                       chkWord("t1_res1", bus.dataOutRes1, 40'd42);
                       chkBit("t1_stall_c6", bus.controlOutStall, 1'b1);
        atNeg(t0 + 7); chkBit("t1_stall_c7", bus.controlOutStall, 1'b0);
        driveAt(t0 + 8);
        bus.controlInReq1 = 1'b0;
        spurQ.delete();

        // 2: tie, lane 1 first; repeated tie, lane 2 first
        t0 = cyc + 2; unitLat = 4;
        driveAt(t0);
        bus.controlInReq1 = 1'b1; bus.dataInRm1 = 40'd2; bus.dataInRn1 = 40'd3;
        bus.controlInReq2 = 1'b1; bus.controlInOp2 = 5'd0; bus.dataInRm2 = 40'd4; bus.dataInRn2 = 40'd5;
        atNeg(t0 + 1);  chkWord("t2_firstA", bus.dataOutUnitA, 40'd2);
        atNeg(t0 + 6);  chkBit("t2_valid1", bus.controlOutResValid1, 1'b1);
                        chkWord("t2_res1", bus.dataOutRes1, 40'd6);
        atNeg(t0 + 7);  chkBit("t2_stall_between", bus.controlOutStall, 1'b1);
        atNeg(t0 + 8);  chkWord("t2_secondA", bus.dataOutUnitA, 40'd4);
        atNeg(t0 + 13); chkBit("t2_valid2", bus.controlOutResValid2, 1'b1);
                        chkWord("t2_res2", bus.dataOutRes2, 40'd20);
        atNeg(t0 + 14); chkBit("t2_stall_release", bus.controlOutStall, 1'b0);
        t1 = t0 + 15;
        driveAt(t1);
        bus.dataInRm1 = 40'd10; bus.dataInRn1 = 40'd10; bus.dataInRm2 = 40'd7; bus.dataInRn2 = 40'd8;
        atNeg(t1 + 1);  chkWord("t2b_firstA", bus.dataOutUnitA, 40'd7);
        atNeg(t1 + 6);  chkWord("t2b_res2", bus.dataOutRes2, 40'd56);
                        chkBit("t2b_valid1_low", bus.controlOutResValid1, 1'b0);
        atNeg(t1 + 13); chkWord("t2b_res1", bus.dataOutRes1, 40'd100);
        atNeg(t1 + 14); chkBit("t2b_stall_release", bus.controlOutStall, 1'b0);
        driveAt(t1 + 15);
        bus.controlInReq1 = 1'b0; bus.controlInReq2 = 1'b0;

        // 3: unit never answers -> watchdog after TMO WAIT cycles
        t0 = cyc + 2; unitLat = 0;
        driveAt(t0);
        bus.controlInReq1 = 1'b1; bus.dataInRm1 = 40'd9; bus.dataInRn1 = 40'd9;
        atNeg(t0 + 65); chkBit("t3_no_early_timeout", bus.controlOutTimeout, 1'b0);
        atNeg(t0 + 66); chkBit("t3_timeout", bus.controlOutTimeout, 1'b1);
                        chkBit("t3_valid1", bus.controlOutResValid1, 1'b1);
                        chkWord("t3_res1", bus.dataOutRes1, 40'd0);
        atNeg(t0 + 67); chkBit("t3_stall_release", bus.controlOutStall, 1'b0);
        driveAt(t0 + 68);
        bus.controlInReq1 = 1'b0;

        // 3b: done on the expiry cycle wins
        t0 = cyc + 2; unitLat = 64;
        driveAt(t0);
        bus.controlInReq1 = 1'b1; bus.dataInRm1 = 40'd3; bus.dataInRn1 = 40'd5;
        atNeg(t0 + 66); chkBit("t3b_no_timeout", bus.controlOutTimeout, 1'b0);
                        chkWord("t3b_res1", bus.dataOutRes1, 40'd15);
        atNeg(t0 + 67); chkBit("t3b_stall_release", bus.controlOutStall, 1'b0);
        driveAt(t0 + 68);
        bus.controlInReq1 = 1'b0;

        // 4: reset in WAIT, late done, then a tie starts with lane 1
        t0 = cyc + 2; unitLat = 8;
        driveAt(t0);
        bus.controlInReq1 = 1'b1; bus.dataInRm1 = 40'd11; bus.dataInRn1 = 40'd2;
        bus.controlInReq2 = 1'b1; bus.dataInRm2 = 40'd1;  bus.dataInRn2 = 40'd1;
        atNeg(t0 + 6);  chkBit("t4_stall_wait", bus.controlOutStall, 1'b1);
        driveAt(t0 + 7);
        rst = 1'b1; bus.controlInReq1 = 1'b0; bus.controlInReq2 = 1'b0;
        driveAt(t0 + 8);
        rst = 1'b0;
        atNeg(t0 + 8);  chkBit("t4_stall", bus.controlOutStall, 1'b0);
                        chkWord("t4_res1", bus.dataOutRes1, 40'd0);
                        chkWord("t4_res2", bus.dataOutRes2, 40'd0);
                        chkWord("t4_unitA", bus.dataOutUnitA, 40'd0);
        atNeg(t0 + 10); chkBit("t4_no_valid1", bus.controlOutResValid1, 1'b0);
                        chkWord("t4_res1_late", bus.dataOutRes1, 40'd0);
        t1 = t0 + 12; unitLat = 3;
        driveAt(t1);
        bus.controlInReq1 = 1'b1; bus.dataInRm1 = 40'd5; bus.dataInRn1 = 40'd5;
        bus.controlInReq2 = 1'b1; bus.dataInRm2 = 40'd6; bus.dataInRn2 = 40'd6;
        atNeg(t1 + 1);  chkWord("t4b_firstA", bus.dataOutUnitA, 40'd5);
        atNeg(t1 + 5);  chkWord("t4b_res1", bus.dataOutRes1, 40'd25);
        atNeg(t1 + 11); chkWord("t4b_res2", bus.dataOutRes2, 40'd36);
        atNeg(t1 + 12); chkBit("t4b_stall_release", bus.controlOutStall, 1'b0);
        driveAt(t1 + 13);
        bus.controlInReq1 = 1'b0; bus.controlInReq2 = 1'b0;

        // 5: operand change during WAIT must not reach the unit (divide)
        t0 = cyc + 2; unitLat = 6;
        driveAt(t0);
        bus.controlInReq1 = 1'b1; bus.controlInOp1 = 5'd1; bus.dataInRm1 = 40'd12; bus.dataInRn1 = 40'd3;
        driveAt(t0 + 3);
        bus.dataInRm1 = 40'hFFFFFFFFFF;
        atNeg(t0 + 4);  chkWord("t5_unitA_held", bus.dataOutUnitA, 40'd12);
        atNeg(t0 + 8);  chkWord("t5_res1", bus.dataOutRes1, 40'd4);
        atNeg(t0 + 9);  chkBit("t5_stall_release", bus.controlOutStall, 1'b0);
        driveAt(t0 + 10);
        bus.controlInReq1 = 1'b0; bus.controlInOp1 = 5'd0; bus.dataInRm1 = '0;

        // 6: back-to-back lane 1 ops; second req drops while in service
        t0 = cyc + 2; unitLat = 2;
        driveAt(t0);
        bus.controlInReq1 = 1'b1; bus.dataInRm1 = 40'd4; bus.dataInRn1 = 40'd4;
        atNeg(t0 + 4);  chkWord("t6_res1_first", bus.dataOutRes1, 40'd16);
        atNeg(t0 + 5);  chkBit("t6_stall_gap", bus.controlOutStall, 1'b0);
                        chkBit("t6_no_reissue", bus.controlOutUnitStart, 1'b0);
        driveAt(t0 + 6);
        bus.dataInRm1 = 40'd5; bus.dataInRn1 = 40'd8;
        atNeg(t0 + 6);  chkBit("t6_stall_new", bus.controlOutStall, 1'b1);
        atNeg(t0 + 7);  chkBit("t6_start_new", bus.controlOutUnitStart, 1'b1);
                        chkWord("t6_unitA_new", bus.dataOutUnitA, 40'd5);
        driveAt(t0 + 8);
        bus.controlInReq1 = 1'b0;
        atNeg(t0 + 10); chkBit("t6_valid1_dropped", bus.controlOutResValid1, 1'b1);
                        chkWord("t6_res1_second", bus.dataOutRes1, 40'd40);
        atNeg(t0 + 12); chkBit("t6_idle_stall", bus.controlOutStall, 1'b0);
                        chkBit("t6_idle_start", bus.controlOutUnitStart, 1'b0);

        atNeg(t0 + 15);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
